// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
package wb_pkg;

   localparam int XLEN = 64;

   localparam logic [63:0] ZERO_64 = 64'h0000_0000_0000_0000;

   // One completed result on its way to the register file / commit record.
   typedef struct packed {
      logic            valid;
      logic            wen;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
      logic [63:0]     pc;
      logic [31:0]     inst;
   } wb_entry_t;

   localparam wb_entry_t WB_ENTRY_EMPTY = '{
      valid : 1'b0,
      wen   : 1'b0,
      rd    : 5'd0,
      data  : {XLEN{1'b0}},
      pc    : ZERO_64,
      inst  : 32'h0000_0000
   };

   // Register-file write enable for an entry: x0 still commits but never writes.
   function automatic logic rf_write_en(input wb_entry_t e);
      return e.valid & e.wen & (e.rd != 5'd0);
   endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry parking slot for an execute result that lost the write port to mul/div.
module wb_hold_slot
   import wb_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      load,
   input  logic      drain,
   input  wb_entry_t din,
   output wb_entry_t q
);

   // Capture on load, release on drain; load and drain are never both set
   // because load needs an empty slot and drain needs a full one.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= WB_ENTRY_EMPTY;
      end else if (load) begin
         q       <= din;
         q.valid <= 1'b1;
      end else if (drain) begin
         q.valid <= 1'b0;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: merges execute and mul/div results onto the single
// register-file write port and produces the commit record and instret count.
module wb_stage
   import wb_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid_i,
   output logic            ex_ready_o,
   input  logic            ex_wen_i,
   input  logic [4:0]      ex_rd_i,
   input  logic [XLEN-1:0] ex_data_i,
   input  logic [63:0]     ex_pc_i,
   input  logic [31:0]     ex_inst_i,
   input  logic            md_valid_i,
   input  logic            md_wen_i,
   input  logic [4:0]      md_rd_i,
   input  logic [XLEN-1:0] md_data_i,
   input  logic [63:0]     md_pc_i,
   input  logic [31:0]     md_inst_i,
   output logic            rf_wen_o,
   output logic [4:0]      rf_waddr_o,
   output logic [XLEN-1:0] rf_wdata_o,
   output logic            commit_valid_o,
   output logic [63:0]     commit_pc_o,
   output logic [31:0]     commit_inst_o,
   output logic [63:0]     instret_o
);

   wb_entry_t ex_entry_s;
   wb_entry_t md_entry_s;
   wb_entry_t sel_s;
   wb_entry_t hold_r;
   wb_entry_t out_r;
   logic      ex_accept_s;
   logic      hold_load_s;
   logic      hold_drain_s;
   logic      rf_wen_r;
   logic [63:0] instret_r;

   // Ready depends only on the hold flag, so no valid-to-ready combinational path.
   assign ex_ready_o  = ~hold_r.valid;
   assign ex_accept_s = ex_valid_i & ~hold_r.valid;

   assign ex_entry_s = '{valid: ex_valid_i, wen: ex_wen_i, rd: ex_rd_i,
                         data: ex_data_i, pc: ex_pc_i, inst: ex_inst_i};
   assign md_entry_s = '{valid: md_valid_i, wen: md_wen_i, rd: md_rd_i,
                         data: md_data_i, pc: md_pc_i, inst: md_inst_i};

   // Fixed priority md > hold > ex; an ex accepted while md is active is parked.
   always_comb begin
      sel_s        = WB_ENTRY_EMPTY;
      hold_load_s  = 1'b0;
      hold_drain_s = 1'b0;
      if (md_valid_i) begin
         sel_s       = md_entry_s;
         hold_load_s = ex_accept_s;
      end else if (hold_r.valid) begin
         sel_s        = hold_r;
         hold_drain_s = 1'b1;
      end else if (ex_accept_s) begin
         sel_s = ex_entry_s;
      end else begin
         sel_s = WB_ENTRY_EMPTY;
      end
   end

   wb_hold_slot u_hold (
      .clk   (clk),
      .rst   (rst),
      .load  (hold_load_s),
      .drain (hold_drain_s),
      .din   (ex_entry_s),
      .q     (hold_r)
   );

   // Output register: whatever was selected this cycle retires on the next.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_r    <= WB_ENTRY_EMPTY;
         rf_wen_r <= 1'b0;
      end else begin
         out_r    <= sel_s;
         rf_wen_r <= rf_write_en(sel_s);
      end
   end

   // Retired-instruction counter, wraps naturally at 2^64.
   always_ff @(posedge clk) begin
      if (rst) begin
         instret_r <= ZERO_64;
      end else if (sel_s.valid) begin
         instret_r <= instret_r + 64'd1;
      end else begin
         instret_r <= instret_r;
      end
   end

   assign rf_wen_o       = rf_wen_r;
   assign rf_waddr_o     = out_r.rd;
   assign rf_wdata_o     = out_r.data;
   assign commit_valid_o = out_r.valid;
   assign commit_pc_o    = out_r.pc;
   assign commit_inst_o  = out_r.inst;
   assign instret_o      = instret_r;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: expected retirements are queued when
// stimulus is driven and popped when the stage commits.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid_i, ex_wen_i, md_valid_i, md_wen_i;
   logic        ex_ready_o;
   logic [4:0]  ex_rd_i, md_rd_i;
   logic [63:0] ex_data_i, md_data_i, ex_pc_i, md_pc_i;
   logic [31:0] ex_inst_i, md_inst_i;
   logic        rf_wen_o, commit_valid_o;
   logic [4:0]  rf_waddr_o;
   logic [63:0] rf_wdata_o, commit_pc_o, instret_o;
   logic [31:0] commit_inst_o;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
      logic [63:0] pc;
      logic [31:0] inst;
      logic        rf_wen;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_instret = 64'd0;

   wb_stage dut (
      .clk(clk), .rst(rst),
      .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_wen_i(ex_wen_i),
      .ex_rd_i(ex_rd_i), .ex_data_i(ex_data_i), .ex_pc_i(ex_pc_i), .ex_inst_i(ex_inst_i),
      .md_valid_i(md_valid_i), .md_wen_i(md_wen_i), .md_rd_i(md_rd_i),
      .md_data_i(md_data_i), .md_pc_i(md_pc_i), .md_inst_i(md_inst_i),
      .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o),
      .commit_inst_o(commit_inst_o), .instret_o(instret_o)
   );

   always #5 clk = ~clk;

   task automatic push_exp(input logic [4:0] rd, input logic [63:0] data,
                           input logic [63:0] pc, input logic [31:0] inst);
      exp_t x;
      x.rd = rd; x.data = data; x.pc = pc; x.inst = inst;
      x.rf_wen = (rd != 5'd0);
      exp_q.push_back(x);
   endtask

   task automatic drive_ex(input logic [4:0] rd, input logic [63:0] data,
                           input logic [63:0] pc, input logic [31:0] inst);
      ex_valid_i = 1'b1; ex_wen_i = 1'b1; ex_rd_i = rd;
      ex_data_i = data; ex_pc_i = pc; ex_inst_i = inst;
   endtask

   task automatic drive_md(input logic [4:0] rd, input logic [63:0] data,
                           input logic [63:0] pc, input logic [31:0] inst);
      md_valid_i = 1'b1; md_wen_i = 1'b1; md_rd_i = rd;
      md_data_i = data; md_pc_i = pc; md_inst_i = inst;
   endtask

   task automatic idle_inputs();
      ex_valid_i = 1'b0; ex_wen_i = 1'b0; ex_rd_i = 5'd0; ex_data_i = 64'd0;
      ex_pc_i = 64'd0; ex_inst_i = 32'd0;
      md_valid_i = 1'b0; md_wen_i = 1'b0; md_rd_i = 5'd0; md_data_i = 64'd0;
      md_pc_i = 64'd0; md_inst_i = 32'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ex_valid_i = 1'($urandom); ex_wen_i = 1'($urandom); ex_rd_i = 5'($urandom);
         ex_data_i = {$urandom, $urandom}; ex_pc_i = {$urandom, $urandom};
         ex_inst_i = $urandom;
         md_valid_i = 1'($urandom); md_wen_i = 1'($urandom); md_rd_i = 5'($urandom);
         md_data_i = {$urandom, $urandom}; md_pc_i = {$urandom, $urandom};
         md_inst_i = $urandom;
         @(posedge clk); #1;
         checks++;
         if (rf_wen_o !== 1'b0 || commit_valid_o !== 1'b0 || instret_o !== 64'd0 || ex_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold cyc%0d: rf_wen=%b commit=%b instret=%0d ready=%b, want 0 0 0 1",
                     i, rf_wen_o, commit_valid_o, instret_o, ex_ready_o);
         end
      end
      rst = 1'b0;
      idle_inputs();
      @(posedge clk); #1;
      checks++;
      if (rf_wen_o !== 1'b0 || commit_valid_o !== 1'b0 || instret_o !== 64'd0 || ex_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: rf_wen=%b commit=%b instret=%0d ready=%b, want 0 0 0 1",
                  rf_wen_o, commit_valid_o, instret_o, ex_ready_o);
      end
   endtask

   task automatic test_single_ex();
      push_exp(5'd5, 64'h1234, 64'h8000_0000, 32'h0050_0293);
      drive_ex(5'd5, 64'h1234, 64'h8000_0000, 32'h0050_0293);
      @(posedge clk); #1;
      idle_inputs();
      exp_instret++;
      checks++;
      if (commit_valid_o !== 1'b1 || exp_q.size() == 0) begin
         errors++;
         $display("FAIL single_ex_commit: commit_valid=%b queued=%0d, want 1", commit_valid_o, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (rf_wen_o !== e.rf_wen || rf_waddr_o !== e.rd || rf_wdata_o !== e.data ||
             commit_pc_o !== e.pc || commit_inst_o !== e.inst) begin
            errors++;
            $display("FAIL single_ex_data: wen=%b rd=%0d data=%h pc=%h inst=%h, want %b %0d %h %h %h",
                     rf_wen_o, rf_waddr_o, rf_wdata_o, commit_pc_o, commit_inst_o,
                     e.rf_wen, e.rd, e.data, e.pc, e.inst);
         end
      end
      checks++;
      if (instret_o !== exp_instret) begin
         errors++;
         $display("FAIL single_ex_instret: got %0d want %0d", instret_o, exp_instret);
      end
      @(posedge clk); #1;
      checks++;
      if (commit_valid_o !== 1'b0 || rf_wen_o !== 1'b0) begin
         errors++;
         $display("FAIL single_ex_idle: commit=%b rf_wen=%b, want 0 0", commit_valid_o, rf_wen_o);
      end
   endtask

   // Collision followed by an ex that must stall while hold is occupied.
   task automatic test_collision();
      logic exp_ready [3] = '{1'b0, 1'b1, 1'b1};
      push_exp(5'd7, 64'hAA, 64'h8000_0100, 32'h0000_0733);
      push_exp(5'd8, 64'hBB, 64'h8000_0104, 32'h0000_0813);
      push_exp(5'd9, 64'hCC, 64'h8000_0108, 32'h0000_0913);
      drive_md(5'd7, 64'hAA, 64'h8000_0100, 32'h0000_0733);
      drive_ex(5'd8, 64'hBB, 64'h8000_0104, 32'h0000_0813);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         md_valid_i = 1'b0;
         // ex 8 was taken at edge 1; ex 9 is presented while ready is low and
         // stays stable until it is actually accepted.
         if (i == 0) drive_ex(5'd9, 64'hCC, 64'h8000_0108, 32'h0000_0913);
         else if (i == 1) ex_valid_i = ex_valid_i;
         else ex_valid_i = 1'b0;
         if (i == 1) ex_valid_i = 1'b1;
         exp_instret++;
         checks++;
         if (commit_valid_o !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL collision_commit e%0d: commit_valid=%b queued=%0d, want 1", i + 1, commit_valid_o, exp_q.size());
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (rf_wen_o !== e.rf_wen || rf_waddr_o !== e.rd || rf_wdata_o !== e.data ||
                commit_pc_o !== e.pc || commit_inst_o !== e.inst) begin
               errors++;
               $display("FAIL collision_data e%0d: wen=%b rd=%0d data=%h pc=%h, want %b %0d %h %h",
                        i + 1, rf_wen_o, rf_waddr_o, rf_wdata_o, commit_pc_o, e.rf_wen, e.rd, e.data, e.pc);
            end
         end
         checks++;
         if (ex_ready_o !== exp_ready[i] || instret_o !== exp_instret) begin
            errors++;
            $display("FAIL collision_ready e%0d: ready=%b instret=%0d, want %b %0d",
                     i + 1, ex_ready_o, instret_o, exp_ready[i], exp_instret);
         end
         if (i == 1) ex_valid_i = 1'b1;
      end
      idle_inputs();
      @(posedge clk); #1;
      checks++;
      if (commit_valid_o !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL collision_tail: commit=%b leftover=%0d, want 0 0", commit_valid_o, exp_q.size());
      end
   endtask

   task automatic test_x0();
      push_exp(5'd0, 64'hFF, 64'h8000_0200, 32'h0ff0_0013);
      drive_ex(5'd0, 64'hFF, 64'h8000_0200, 32'h0ff0_0013);
      @(posedge clk); #1;
      idle_inputs();
      exp_instret++;
      checks++;
      if (commit_valid_o !== 1'b1 || exp_q.size() == 0) begin
         errors++;
         $display("FAIL x0_commit: commit_valid=%b, want 1", commit_valid_o);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (rf_wen_o !== e.rf_wen || commit_pc_o !== e.pc || rf_waddr_o !== e.rd) begin
            errors++;
            $display("FAIL x0_wen: rf_wen=%b pc=%h rd=%0d, want %b %h %0d",
                     rf_wen_o, commit_pc_o, rf_waddr_o, e.rf_wen, e.pc, e.rd);
         end
      end
      checks++;
      if (instret_o !== exp_instret) begin
         errors++;
         $display("FAIL x0_instret: got %0d want %0d", instret_o, exp_instret);
      end
   endtask

   task automatic test_md_burst();
      exp_t parked;
      parked.rd = 5'd14; parked.data = 64'h1400; parked.pc = 64'h8000_0314;
      parked.inst = 32'h0000_0713; parked.rf_wen = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            drive_md(5'(10 + i), 64'h1000 + 64'(i), 64'h8000_0300 + 64'(4 * i), 32'h0000_0533 + 32'(i));
            push_exp(5'(10 + i), 64'h1000 + 64'(i), 64'h8000_0300 + 64'(4 * i), 32'h0000_0533 + 32'(i));
         end else begin
            md_valid_i = 1'b0;
            exp_q.push_back(parked);
         end
         if (i == 0) drive_ex(parked.rd, parked.data, parked.pc, parked.inst);
         else ex_valid_i = 1'b0;
         @(posedge clk); #1;
         exp_instret++;
         checks++;
         if (commit_valid_o !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL burst_commit e%0d: commit_valid=%b, want 1", i + 1, commit_valid_o);
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (rf_wen_o !== e.rf_wen || rf_waddr_o !== e.rd || rf_wdata_o !== e.data || commit_pc_o !== e.pc) begin
               errors++;
               $display("FAIL burst_data e%0d: wen=%b rd=%0d data=%h pc=%h, want %b %0d %h %h",
                        i + 1, rf_wen_o, rf_waddr_o, rf_wdata_o, commit_pc_o, e.rf_wen, e.rd, e.data, e.pc);
            end
         end
         checks++;
         if (ex_ready_o !== (i == 4) || instret_o !== exp_instret) begin
            errors++;
            $display("FAIL burst_ready e%0d: ready=%b instret=%0d, want %b %0d",
                     i + 1, ex_ready_o, instret_o, (i == 4), exp_instret);
         end
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         drive_ex(5'(20 + i), 64'hB000 + 64'(i), 64'h8000_0400 + 64'(4 * i), 32'h0000_0a13 + 32'(i));
         push_exp(5'(20 + i), 64'hB000 + 64'(i), 64'h8000_0400 + 64'(4 * i), 32'h0000_0a13 + 32'(i));
         @(posedge clk); #1;
         exp_instret++;
         checks++;
         if (commit_valid_o !== 1'b1 || exp_q.size() == 0 || ex_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_commit e%0d: commit_valid=%b ready=%b, want 1 1", i + 1, commit_valid_o, ex_ready_o);
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (rf_waddr_o !== e.rd || rf_wdata_o !== e.data || instret_o !== exp_instret) begin
               errors++;
               $display("FAIL b2b_data e%0d: rd=%0d data=%h instret=%0d, want %0d %h %0d",
                        i + 1, rf_waddr_o, rf_wdata_o, instret_o, e.rd, e.data, exp_instret);
            end
         end
      end
      idle_inputs();
      @(posedge clk); #1;
   endtask

   task automatic test_reset_hold_full();
      push_exp(5'd7, 64'hAA, 64'h8000_0500, 32'h0000_0733);
      drive_md(5'd7, 64'hAA, 64'h8000_0500, 32'h0000_0733);
      drive_ex(5'd8, 64'hBB, 64'h8000_0504, 32'h0000_0813);
      @(posedge clk); #1;
      idle_inputs();
      exp_instret++;
      checks++;
      if (commit_valid_o !== 1'b1 || exp_q.size() == 0 || ex_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL rsthold_e1: commit_valid=%b ready=%b, want 1 0", commit_valid_o, ex_ready_o);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (rf_waddr_o !== e.rd || rf_wdata_o !== e.data) begin
            errors++;
            $display("FAIL rsthold_e1_data: rd=%0d data=%h, want %0d %h", rf_waddr_o, rf_wdata_o, e.rd, e.data);
         end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_instret = 64'd0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (commit_valid_o !== 1'b0 || rf_wen_o !== 1'b0 || instret_o !== 64'd0 || ex_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rsthold_after c%0d: commit=%b rf_wen=%b rd=%0d instret=%0d ready=%b, want 0 0 - 0 1",
                     i, commit_valid_o, rf_wen_o, rf_waddr_o, instret_o, ex_ready_o);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single_ex();
      test_collision();
      test_x0();
      test_md_burst();
      test_back_to_back();
      test_reset_hold_full();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
